// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution read sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package conv_pkg;

  // Read-to-datapath-output latency and the drain length that follows the last read
  localparam int CONV_LAT = 3;
  localparam int PIX_W    = 8;
  localparam int KER_W    = 3;
  localparam int COORD_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // One tag travels alongside each pixel read so the window position lines up with the datapath
  typedef struct packed {
    logic               issued;
    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row;
  } tag_t;

endpackage

// File: rtl/conv_addr_gen.sv
// Raster-scan pixel address generator: column, row and linear address of the current read.
// Latency: outputs are registered; a new position appears the cycle after inc.
// Backpressure: none; advances on every cycle inc is high, clr has priority.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               clr,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic [ADDR_W-1:0]  addr,
  output logic               last
);

  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [COORD_W-1:0] COL_MAX   = COORD_W'(IMG_W - 1);

  logic [COORD_W-1:0] r_col;
  logic [COORD_W-1:0] r_row;
  logic [ADDR_W-1:0]  r_addr;

  // Step through the frame in raster order; the column wraps into the next row,
  // and the whole counter wraps to zero after the final pixel
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_col  <= '0;
      r_row  <= '0;
      r_addr <= '0;
    end else if (inc) begin
      if (r_addr == LAST_ADDR) begin
        r_col  <= '0;
        r_row  <= '0;
        r_addr <= '0;
      end else begin
        r_addr <= r_addr + ADDR_W'(1);
        if (r_col == COL_MAX) begin
          r_col <= '0;
          r_row <= r_row + COORD_W'(1);
        end else begin
          r_col <= r_col + COORD_W'(1);
        end
      end
    end
  end

  assign col  = r_col;
  assign row  = r_row;
  assign addr = r_addr;
  assign last = (r_addr == LAST_ADDR);

endmodule

// File: rtl/conv_sequencer.sv
// Frame sequencer for a 1x3 convolution: streams pixel reads and tags valid in-row windows.
// Latency: a read issued in cycle t is reported (out_valid/out_x/out_y) in cycle t+CONV_LAT.
// Backpressure: none; reads issue every RUN cycle. CONV_SEQUENCER_PERF_EN adds frame_cycles.
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 19
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic signed [KER_W-1:0]  kernel_in,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic signed [PIX_W-1:0]  rd_data,
  output logic signed [PIX_W-1:0]  conv_in,
  output logic signed [KER_W-1:0]  conv_kernel,
  output logic                     out_valid,
  output logic [COORD_W-1:0]       out_x,
  output logic [COORD_W-1:0]       out_y,
  output logic                     busy,
  output logic                     done
`ifdef CONV_SEQUENCER_PERF_EN
  ,
  output logic [31:0]              frame_cycles
`endif
);

  state_t                   r_state;
  state_t                   w_next;
  logic [1:0]               r_drain_cnt;
  logic signed [KER_W-1:0]  r_kernel;
  tag_t                     r_tag [CONV_LAT-1];
  logic                     r_out_valid;
  logic [COORD_W-1:0]       r_out_x;
  logic [COORD_W-1:0]       r_out_y;

  logic [COORD_W-1:0]       w_col;
  logic [COORD_W-1:0]       w_row;
  logic [ADDR_W-1:0]        w_addr;
  logic                     w_last;
  logic                     w_start_acc;
  logic                     w_win;

  // Abort beats a simultaneous start, so a start is only taken when abort is low
  assign w_start_acc = (r_state == ST_IDLE) && start && !abort;

  conv_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk  (clk),
    .rst  (rst),
    .inc  (r_state == ST_RUN),
    .clr  (abort || (r_state != ST_RUN)),
    .col  (w_col),
    .row  (w_row),
    .addr (w_addr),
    .last (w_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore outputs; abort returns to IDLE from anywhere
  always_comb begin
    w_next = r_state;
    rd_en  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_RUN;
      end
      ST_RUN: begin
        rd_en = 1'b1;
        busy  = 1'b1;
        if (w_last) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (r_drain_cnt == 2'(CONV_LAT - 1)) w_next = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (abort) w_next = ST_IDLE;
  end

  // Drain lasts CONV_LAT cycles so the last read's result is out before DONE
  always_ff @(posedge clk) begin
    if (rst || (r_state != ST_DRAIN)) begin
      r_drain_cnt <= '0;
    end else begin
      r_drain_cnt <= r_drain_cnt + 2'd1;
    end
  end

  // Kernel is captured only when a frame is accepted and held for its duration
  always_ff @(posedge clk) begin
    if (rst) begin
      r_kernel <= '0;
    end else if (w_start_acc) begin
      r_kernel <= kernel_in;
    end
  end

  // A window is complete once the third pixel of a row (col >= 2) reaches the output
  assign w_win = r_tag[CONV_LAT-2].issued && (r_tag[CONV_LAT-2].col >= COORD_W'(2));

  // Tag pipeline; the final stage is the registered window report, coordinates hold between windows
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CONV_LAT - 1; i++) r_tag[i] <= '0;
      r_out_valid <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
    end else if (abort) begin
      for (int i = 0; i < CONV_LAT - 1; i++) r_tag[i] <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_tag[0] <= '{issued: rd_en, col: w_col, row: w_row};
      for (int i = 1; i < CONV_LAT - 1; i++) r_tag[i] <= r_tag[i-1];
      r_out_valid <= w_win;
      if (w_win) begin
        r_out_x <= r_tag[CONV_LAT-2].col - COORD_W'(1);
        r_out_y <= r_tag[CONV_LAT-2].row;
      end
    end
  end

  assign rd_addr     = w_addr;
  assign conv_in     = rd_data;
  assign conv_kernel = r_kernel;
  assign out_valid   = r_out_valid;
  assign out_x       = r_out_x;
  assign out_y       = r_out_y;

`ifdef CONV_SEQUENCER_PERF_EN
  logic [31:0] r_cyc;
  logic [31:0] r_frame_cycles;

  // Running cycle count of the current frame, starting at 1 in the first RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc <= '0;
    end else if (w_start_acc) begin
      r_cyc <= 32'd1;
    end else if (busy) begin
      r_cyc <= r_cyc + 32'd1;
    end
  end

  // Publish the total (DONE cycle included) as DONE is entered; aborted frames leave it untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cycles <= '0;
    end else if ((r_state == ST_DRAIN) && (w_next == ST_DONE)) begin
      r_frame_cycles <= r_cyc + 32'd1;
    end
  end

  assign frame_cycles = r_frame_cycles;
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// Randomized scoreboard bench for conv_sequencer on a 4x2 image.
// Expected reads, windows and done pulses are queued per frame with their cycle numbers.
// A negedge monitor pops and compares whatever the DUT presents each cycle.
module tb_conv_sequencer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 3;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [2:0]    kernel_in;
  logic [7:0]    rd_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    conv_in;
  logic [2:0]    conv_kernel;
  logic          out_valid;
  logic [15:0]   out_x;
  logic [15:0]   out_y;
  logic          busy;
  logic          done;
`ifdef CONV_SEQUENCER_PERF_EN
  logic [31:0]   frame_cycles;
  int            exp_fc = 0;
`endif

  always #5 clk = ~clk;

  conv_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .kernel_in   (kernel_in),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .conv_in     (conv_in),
    .conv_kernel (conv_kernel),
    .out_valid   (out_valid),
    .out_x       (out_x),
    .out_y       (out_y),
    .busy        (busy),
    .done        (done)
`ifdef CONV_SEQUENCER_PERF_EN
    ,
    .frame_cycles(frame_cycles)
`endif
  );

  typedef struct {
    int t;
    int a;
    int b;
  } ev_t;

  ev_t        q_rd[$];
  ev_t        q_out[$];
  ev_t        q_done[$];
  int         cyc     = 0;
  int         checks  = 0;
  int         errors  = 0;
  bit         mon_en  = 1'b0;
  int         busy_lo = 1;
  int         busy_hi = 0;
  int         k_chg   = 0;
  logic [2:0] k_prev  = 3'd0;
  logic [2:0] k_new   = 3'd0;
  int         rst_cyc = -10;
  logic [7:0] drv_data = 8'd0;
  int         hx = 0;
  int         hy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [2:0] exp_k(input int m);
    return (m >= k_chg) ? k_new : k_prev;
  endfunction

  // Monitor: compares every cycle against the queued expectations
  always @(negedge clk) begin : mon
    int m;
    bit e;
    if (mon_en) begin
      m = cyc;
      if (m == rst_cyc + 1) begin
        hx = 0;
        hy = 0;
      end
      chk("busy", 64'(busy), 64'((m >= busy_lo) && (m <= busy_hi)));
      chk("conv_kernel", 64'(conv_kernel), 64'(exp_k(m)));
      chk("conv_in", 64'(conv_in), 64'(drv_data));

      e = (q_rd.size() > 0) && (q_rd[0].t == m);
      chk("rd_en", 64'(rd_en), 64'(e));
      if (e) begin
        if (rd_en) chk("rd_addr", 64'(rd_addr), 64'(q_rd[0].a));
        void'(q_rd.pop_front());
      end

      e = (q_out.size() > 0) && (q_out[0].t == m);
      chk("out_valid", 64'(out_valid), 64'(e));
      if (e) begin
        hx = q_out[0].a;
        hy = q_out[0].b;
        void'(q_out.pop_front());
        if (out_valid) begin
          chk("out_x", 64'(out_x), 64'(hx));
          chk("out_y", 64'(out_y), 64'(hy));
        end
      end else begin
        chk("out_x_hold", 64'(out_x), 64'(hx));
        chk("out_y_hold", 64'(out_y), 64'(hy));
      end

      e = (q_done.size() > 0) && (q_done[0].t == m);
      chk("done", 64'(done), 64'(e));
      if (e) void'(q_done.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    drv_data = 8'($urandom);
    rd_data  = drv_data;
  endtask

  // Drop every expectation scheduled after cycle a (frame cut short at a)
  task automatic purge(input int a);
    while (q_rd.size() > 0 && q_rd[$].t > a) void'(q_rd.pop_back());
    while (q_out.size() > 0 && q_out[$].t > a) void'(q_out.pop_back());
    while (q_done.size() > 0 && q_done[$].t > a) void'(q_done.pop_back());
    if (busy_hi > a) busy_hi = a;
  endtask

  task automatic check_reset();
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_kernel", 64'(conv_kernel), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_x", 64'(out_x), 64'd0);
    chk("rst_out_y", 64'(out_y), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
`ifdef CONV_SEQUENCER_PERF_EN
    exp_fc = 0;
    chk("rst_frame_cycles", 64'(frame_cycles), 64'd0);
`endif
  endtask

  // mode 0: full frame, 1: abort at offset 'at' (0 = with start), 2: reset at offset 'at'.
  // Offsets count cycles after the one in which start is driven; stray>0 pulses start then.
  task automatic run_frame(input logic [2:0] k, input int mode, input int at, input int stray);
    int c;
    c = cyc;
    start     = 1'b1;
    kernel_in = k;
    if (mode == 1 && at == 0) begin
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      return;
    end
    k_prev = exp_k(c);
    k_new  = k;
    k_chg  = c + 1;
    for (int i = 0; i < N; i++) begin
      q_rd.push_back('{c + 1 + i, i, 0});
      if ((i % W) >= 2) q_out.push_back('{c + 4 + i, (i % W) - 1, i / W});
    end
    q_done.push_back('{c + N + 4, 0, 0});
    busy_lo = c + 1;
    busy_hi = c + N + 3;
    for (int j = 1; j <= N + 4; j++) begin
      tick();
      start     = 1'b0;
      abort     = 1'b0;
      kernel_in = 3'($urandom);
      if (j == stray) start = 1'b1;
      if (mode == 1 && j == at) begin
        abort = 1'b1;
        purge(cyc);
        tick();
        abort = 1'b0;
        start = 1'b0;
`ifdef CONV_SEQUENCER_PERF_EN
        chk("frame_cycles_abort", 64'(frame_cycles), 64'(exp_fc));
`endif
        return;
      end
      if (mode == 2 && j == at) begin
        rst = 1'b1;
        purge(cyc);
        k_prev  = exp_k(cyc);
        k_new   = 3'd0;
        k_chg   = cyc + 1;
        rst_cyc = cyc;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        #2;
        check_reset();
        return;
      end
    end
    tick();
    start = 1'b0;
`ifdef CONV_SEQUENCER_PERF_EN
    exp_fc = N + 4;
    chk("frame_cycles", 64'(frame_cycles), 64'(exp_fc));
`endif
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    kernel_in = 3'd0;
    rd_data   = 8'd0;
    tick();
    tick();
    #2;
    check_reset();
    rst    = 1'b0;
    mon_en = 1'b1;

    // Directed: basic frame with stray start while busy, abort, mid-frame reset, clean rerun,
    // and start coinciding with abort
    run_frame(3'b011, 0, 0, 5);
    run_frame(3'b110, 1, 5, 0);
    run_frame(3'b101, 2, 3, 0);
    run_frame(3'b010, 0, 0, N + 4);
    run_frame(3'b111, 1, 0, 0);
    tick();

    for (int f = 0; f < 30; f++) begin
      int mode;
      int at;
      int gap;
      mode = int'($urandom_range(0, 2));
      at   = int'($urandom_range((mode == 1) ? 0 : 1, N + 4));
      gap  = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) tick();
      run_frame(3'($urandom), mode, at, int'($urandom_range(0, N + 4)));
    end

    repeat (6) tick();
    chk("rd_queue_empty", 64'(q_rd.size()), 64'd0);
    chk("out_queue_empty", 64'(q_out.size()), 64'd0);
    chk("done_queue_empty", 64'(q_done.size()), 64'd0);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/conv_sequencer.md
CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 Parameter IMG_W, default 640, pixels per row (SHALL be >= 3).
REQ-002 Parameter IMG_H, default 480, rows per frame (SHALL be >= 1).
REQ-003 Parameter ADDR_W, default 19, pixel memory address width (2^ADDR_W >= IMG_W*IMG_H).
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  frame request; sampled only in IDLE.
REQ-007 abort  in  1  cancel the current frame.
REQ-008 kernel_in  in  3 signed  kernel taps; latched on accepted start.
REQ-009 rd_en  out  1  pixel memory read strobe.
REQ-010 rd_addr  out  ADDR_W  linear pixel address, row*IMG_W+col.
REQ-011 rd_data  in  8 signed  memory data, valid exactly 1 cycle after rd_en.
REQ-012 conv_in  out  8 signed  datapath pixel input, combinational pass-through of rd_data.
REQ-013 conv_kernel  out  3 signed  datapath kernel, driven from the latched register.
REQ-014 out_valid  out  1  datapath output_data is a full in-row 3-pixel window this cycle.
REQ-015 out_x  out  16  column of window centre pixel; out_y  out  16  its row.
REQ-016 busy  out  1  frame in progress; done  out  1  one-cycle end-of-frame pulse.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-018 IDLE->RUN on the edge where start=1; kernel_in is latched at the same edge.
REQ-019 In RUN, rd_en SHALL be 1 every cycle, with rd_addr starting at 0 and incrementing by 1 to IMG_W*IMG_H-1.
REQ-020 RUN->DRAIN after the cycle that issues the last address; DRAIN SHALL last exactly 3 cycles with rd_en=0.
REQ-021 DRAIN->DONE->IDLE; done=1 only in DONE.
REQ-022 busy SHALL be 1 in RUN and DRAIN, and 0 in IDLE and DONE.
REQ-023 Datapath latency is fixed: a read issued in cycle t produces its output_data contribution in cycle t+3.
REQ-024 A 3-stage tag pipeline SHALL carry (issued, col, row); out_valid=1 in cycle t+3 iff the read at t had col >= 2.
REQ-025 out_x SHALL be col-1 and out_y SHALL be row of the tagged read; both hold their last value when out_valid=0.
REQ-026 The column counter SHALL wrap IMG_W-1->0 with the row counter incrementing; windows never straddle rows, so each row yields IMG_W-2 valid outputs.
REQ-027 start while busy or in DONE SHALL be ignored; kernel_in changes during a frame SHALL be ignored.
REQ-028 abort=1 in any state SHALL go to IDLE at the next edge, clear the tag pipeline and drive rd_en=0, with no done pulse; abort wins over a simultaneous start.

Reset
REQ-029 rst SHALL take priority over start and abort.
REQ-030 On reset, state=IDLE and rd_en=rd_addr=0.
REQ-031 On reset, the latched kernel=0, out_valid=0, out_x=out_y=0, busy=0 and done=0.
REQ-032 Reset mid-frame SHALL discard the frame; no done pulse follows.

Configuration
REQ-033 With CONV_SEQUENCER_PERF_EN defined: add output frame_cycles (32), counting cycles from the accepted start to DONE inclusive; it updates in DONE and holds otherwise (reset 0).
REQ-034 Without CONV_SEQUENCER_PERF_EN, the port and counter SHALL be absent; all other behaviour is identical.

Structure
REQ-035 A shared package conv_pkg SHALL hold the FSM state enum, the latency constant CONV_LAT=3, and the pixel and kernel width constants.
REQ-036 The row/column/linear-address counter SHALL be a sub-module conv_addr_gen (inc, clr; outputs col, row, addr, last).

Verification (IMG_W=4, IMG_H=2, start at edge 0)
REQ-037 Basic frame: rd_en high in cycles 1..8 with addr 0..7; out_valid in cycles 6,7,10,11 with (x,y)=(1,0),(2,0),(1,1),(2,1); busy 1..11; done in cycle 12.
REQ-038 Kernel latch: kernel_in=3'b011 at start, changed to 3'b101 in cycle 4 -> conv_kernel stays 011 for the whole frame.
REQ-039 Start while busy: start pulsed in cycle 5 -> ignored; exactly one done, in cycle 12.
REQ-040 Abort: abort in cycle 5 -> IDLE in cycle 6, rd_en=0 and out_valid=0 from cycle 6, no done.
REQ-041 Reset mid-frame: rst in cycle 3 -> all outputs at reset values in cycle 4; a new start then runs a clean frame.
REQ-042 Perf counter (macro on): frame_cycles=12 after the basic frame; start and abort in the same cycle -> IDLE.
